// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM encoding and port ids for mem_arbiter
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Bit positions of the two requesters in request/grant vectors
  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with one-hot grant
import mem_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  // 1 when port D held the most recent grant, 0 when port I did
  logic r_last_d;

  // On a tie, hand the grant to the port that was not served last
  always_comb begin
    o_grant = i_req;
    if (i_req[PORT_I] && i_req[PORT_D]) begin
      o_grant = 2'b00;
      if (r_last_d) begin
        o_grant[PORT_I] = 1'b1;
      end else begin
        o_grant[PORT_D] = 1'b1;
      end
    end
  end

  // Remember the winner once the grant is actually taken; reset favours I
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_last_d <= 1'b1;
    end else if (i_update) begin
      r_last_d <= o_grant[PORT_D];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter in front of a single-port word memory
import mem_pkg::*;

module mem_arbiter #(
  parameter int          BITS       = 32,
  parameter int          WORD_DEPTH = 32,
  parameter logic [31:0] OFFSET     = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [BITS-1:0] i_req_addr,
  output logic            i_resp_valid,
  input  logic            i_resp_ready,
  output logic [BITS-1:0] i_resp_rdata,
  output logic            i_resp_err,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [BITS-1:0] d_req_addr,
  input  logic            d_req_wen,
  input  logic [BITS-1:0] d_req_wdata,
  output logic            d_resp_valid,
  input  logic            d_resp_ready,
  output logic [BITS-1:0] d_resp_rdata,
  output logic            d_resp_err,
  output logic            mem_wen,
  output logic [BITS-1:0] mem_a,
  output logic [BITS-1:0] mem_d,
  input  logic [BITS-1:0] mem_q,
  output logic [31:0]     mem_offset
);

  // One extra bit so the end-of-window bound cannot wrap
  localparam int               AW      = BITS + 1;
  localparam logic [AW-1:0]    LP_BASE = AW'(OFFSET);
  localparam logic [AW-1:0]    LP_END  = LP_BASE + AW'(4 * WORD_DEPTH);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      w_grant;
  logic            w_accept;
  logic            w_sel_d;
  logic [BITS-1:0] w_addr;
  logic            w_wen;
  logic [BITS-1:0] w_wdata;
  logic [AW-1:0]   w_addr_ext;
  logic            w_addr_err;
  logic            w_resp_hs;

  logic [BITS-1:0] r_addr;
  logic [BITS-1:0] r_wdata;
  logic            r_wen;
  logic            r_port_d;
  logic [BITS-1:0] r_rdata;
  logic            r_err;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    ({d_req_valid, i_req_valid}),
    .i_update (w_accept),
    .o_grant  (w_grant)
  );

  assign mem_offset = OFFSET;

  // Pick the granted request and classify its address
  always_comb begin
    w_accept   = (r_state == IDLE) && (|w_grant) && !rst_n;
    w_sel_d    = w_grant[PORT_D];
    w_addr     = w_sel_d ? d_req_addr : i_req_addr;
    w_wen      = w_sel_d && d_req_wen;
    w_wdata    = w_sel_d ? d_req_wdata : '0;
    w_addr_ext = {1'b0, w_addr};
    w_addr_err = (w_addr_ext < LP_BASE) || (w_addr_ext >= LP_END) || (w_addr[1:0] != 2'b00);
    w_resp_hs  = (r_state == RESP) && (r_port_d ? d_resp_ready : i_resp_ready);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: bad addresses bypass the memory cycle entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_addr_err ? RESP : ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    if (w_resp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs: memory bus idles at zero, responses go only to the granted port
  always_comb begin
    i_req_ready  = w_accept && w_grant[PORT_I];
    d_req_ready  = w_accept && w_grant[PORT_D];
    mem_wen      = 1'b0;
    mem_a        = '0;
    mem_d        = '0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    i_resp_rdata = '0;
    d_resp_rdata = '0;
    i_resp_err   = 1'b0;
    d_resp_err   = 1'b0;
    case (r_state)
      ACCESS: begin
        mem_wen = r_wen && !rst_n;
        mem_a   = r_addr;
        mem_d   = r_wdata;
      end
      RESP: begin
        if (r_port_d) begin
          d_resp_valid = 1'b1;
          d_resp_rdata = r_rdata;
          d_resp_err   = r_err;
        end else begin
          i_resp_valid = 1'b1;
          i_resp_rdata = r_rdata;
          i_resp_err   = r_err;
        end
      end
      default: ;
    endcase
  end

  // Latch the accepted request and capture read data at the end of ACCESS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wen    <= 1'b0;
      r_port_d <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_wen    <= w_wen;
      r_port_d <= w_sel_d;
      r_rdata  <= '0;
      r_err    <= w_addr_err;
    end else if ((r_state == ACCESS) && !r_wen) begin
      r_rdata  <= mem_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_resp_err;
  logic [31:0] i_req_addr, i_resp_rdata;
  logic        d_req_valid, d_req_ready, d_req_wen, d_resp_valid, d_resp_ready, d_resp_err;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
  logic        mem_wen;
  logic [31:0] mem_a, mem_d, mem_q, mem_offset;

  always #5 clk = ~clk;

  mem_arbiter #(.BITS(32), .WORD_DEPTH(32), .OFFSET(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
    .i_resp_rdata(i_resp_rdata), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q), .mem_offset(mem_offset)
  );

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          wen_cnt = 0;
  logic        mem_init = 1'b0;
  logic [31:0] mem [0:31];
  logic [31:0] ref_mem [0:31];
  exp_t        exp_q[$];
  int          grant_log[$];
  bit          seen = 0;
  bit          hold_v = 0;
  logic [31:0] hold_rd;
  exp_t        m_e;
  logic        m_rv, m_rr, m_er;
  logic [31:0] m_rd;
  int          m_rp;

  function automatic logic [31:0] init_val(input int k);
    return (k == 0) ? 32'hDEADBEEF : 32'h5A000000 + 32'(k) * 32'h00010203;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // External word memory: asynchronous read, write on the rising edge
  assign mem_q = mem[mem_a[6:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 32; k++) mem[k] <= init_val(k);
    end else if (mem_wen) begin
      mem[mem_a[6:2]] <= mem_d;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int p, input logic [31:0] a, input logic w, input logic [31:0] wd);
    exp_t e;
    e.port  = p;
    e.err   = (a >= 32'h80) || (a[1:0] != 2'b00);
    e.rdata = (e.err || w) ? 32'h0 : ref_mem[a[6:2]];
    e.lat   = e.err ? 1 : 2;
    e.acc   = cyc;
    e.wen   = w;
    e.addr  = a;
    e.wdata = wd;
    exp_q.push_back(e);
    grant_log.push_back(p);
  endtask

  // Monitor: push on accept, compare on response; writes commit to the model on completion
  always @(negedge clk) begin
    if (mem_init) for (int k = 0; k < 32; k++) ref_mem[k] = init_val(k);
    if (mem_wen) wen_cnt++;
    if (rst_n) begin
      exp_q.delete();
      seen   = 0;
      hold_v = 0;
    end else begin
      if (i_req_valid && i_req_ready) push_exp(0, i_req_addr, 1'b0, 32'h0);
      if (d_req_valid && d_req_ready) push_exp(1, d_req_addr, d_req_wen, d_req_wdata);
      if (i_req_ready || d_req_ready) check("ready_onehot", i_req_ready & d_req_ready, 0);
      m_rv = i_resp_valid | d_resp_valid;
      m_rp = d_resp_valid ? 1 : 0;
      m_rr = (m_rp == 1) ? d_resp_ready : i_resp_ready;
      m_rd = (m_rp == 1) ? d_resp_rdata : i_resp_rdata;
      m_er = (m_rp == 1) ? d_resp_err : i_resp_err;
      if (hold_v) begin
        check("hold_valid", m_rv, 1);
        check("hold_rdata", m_rd, hold_rd);
        hold_v = 0;
      end
      if (m_rv) begin
        check("resp_onehot", i_resp_valid & d_resp_valid, 0);
        check("resp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          m_e = exp_q[0];
          if (!seen) begin
            check("resp_port", m_rp, m_e.port);
            check("resp_latency", cyc - m_e.acc, m_e.lat);
            seen = 1;
          end
          if (m_rr) begin
            check("resp_rdata", m_rd, m_e.rdata);
            check("resp_err", m_er, m_e.err);
            if (m_e.wen && !m_e.err) ref_mem[m_e.addr[6:2]] = m_e.wdata;
            void'(exp_q.pop_front());
            seen = 0;
          end else begin
            hold_v  = 1;
            hold_rd = m_rd;
          end
        end
      end
    end
  end

  task automatic send(input int p, input logic [31:0] a, input logic w, input logic [31:0] wd);
    bit got = 0;
    int k;
    if (p == 0) begin
      i_req_valid = 1'b1; i_req_addr = a;
    end else begin
      d_req_valid = 1'b1; d_req_addr = a; d_req_wen = w; d_req_wdata = wd;
    end
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if ((p == 0) ? i_req_ready : d_req_ready) begin
        got = 1;
        break;
      end
    end
    check("accept", got, 1);
    check("accept_wait", k, 0);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic both_valid(input int n, input int first);
    int base = grant_log.size();
    int k = 0;
    i_req_valid = 1'b1; i_req_addr = 32'h4;
    d_req_valid = 1'b1; d_req_addr = 32'hC; d_req_wen = 1'b0;
    while (grant_log.size() < base + n && k < 80) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    check("rr_count", grant_log.size() >= base + n, 1);
    for (int j = 0; j < n; j++) begin
      if (grant_log.size() > base + j) check("rr_order", grant_log[base + j], (first + j) % 2);
    end
    drain();
  endtask

  logic [31:0] old_w;

  initial begin
    rst_n = 1'b1; mem_init = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h0; i_resp_ready = 1'b1;
    d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wen = 1'b0; d_req_wdata = 32'h0; d_resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i_req_ready", i_req_ready, 0);
    check("rst_resp_valid", {i_resp_valid, d_resp_valid}, 0);
    check("rst_mem_bus", {mem_wen, mem_a, mem_d}, 0);
    check("rst_rdata_err", {i_resp_rdata, i_resp_err, d_resp_err}, 0);
    check("mem_offset", mem_offset, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_init = 1'b0; i_req_valid = 1'b0;

    // First read returns the preloaded word with two-cycle latency
    send(0, 32'h0, 1'b0, 32'h0);
    drain();

    // Write then read back from the fetch port
    send(1, 32'h10, 1'b1, 32'h12345678);
    drain();
    send(0, 32'h10, 1'b0, 32'h0);
    drain();

    // Leave D as last winner, then contend for four transactions
    send(1, 32'h8, 1'b0, 32'h0);
    drain();
    both_valid(4, 0);

    // Address errors never touch memory; last in-range word still works
    old_w = 32'(wen_cnt);
    send(1, 32'h80, 1'b1, 32'h11111111);
    drain();
    send(1, 32'h06, 1'b1, 32'h22222222);
    drain();
    send(0, 32'h81, 1'b0, 32'h0);
    drain();
    check("err_no_wen", wen_cnt, old_w);
    send(1, 32'h7C, 1'b1, 32'h0BADF00D);
    drain();
    send(0, 32'h7C, 1'b0, 32'h0);
    drain();

    // Back-pressure on the D response with I waiting
    d_resp_ready = 1'b0;
    send(1, 32'h10, 1'b0, 32'h0);
    i_req_valid = 1'b1; i_req_addr = 32'h0;
    @(negedge clk);
    check("access_no_grant", i_req_ready, 0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("hold_no_grant", i_req_ready, 0);
      check("hold_dvalid", d_resp_valid, 1);
    end
    @(posedge clk); #1;
    d_resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("resume_grant", i_req_ready, 1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    drain();

    // Reset during the ACCESS cycle of a write abandons it
    old_w = mem[8];
    send(1, 32'h20, 1'b1, 32'hCAFEF00D);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_access_wen", mem_wen, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_word_kept", mem[8], old_w);
    check("rst_resp_idle", {i_resp_valid, d_resp_valid, d_resp_err, d_resp_rdata}, 0);
    check("rst_bus_idle", {mem_wen, mem_a, mem_d}, 0);
    @(posedge clk); #1;

    // Reset restores I as first winner of a tie
    both_valid(2, 0);
    send(0, 32'h20, 1'b0, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
